// File: rtl/vote_if.sv
// Handshake bundle between the vote source and the collector; ballot feeds the
// downstream majority classifier directly.
interface vote_if;
  logic       start;
  logic [3:0] cast;
  logic [3:0] choice;
  logic [3:0] ballot;
  logic       ballot_valid;
  logic       busy;
  logic [3:0] voted;
  logic       timed_out;

  modport master (
    output start, cast, choice,
    input  ballot, ballot_valid, busy, voted, timed_out
  );

  modport slave (
    input  start, cast, choice,
    output ballot, ballot_valid, busy, voted, timed_out
  );
endinterface

// File: rtl/vote_collector.sv
// Timed 4-voter ballot collector: one locked vote per voter per window, closes on
// full turnout or timer expiry, then holds the ballot until the next start.
module vote_collector #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int TIMER_W       = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  vote_if.slave  bus
);

  localparam int                 NUM_VOTERS = 4;
  localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [NUM_VOTERS-1:0]   vote_q, vote_d;
  logic [NUM_VOTERS-1:0]   voted_q, voted_d;
  logic [NUM_VOTERS-1:0]   ballot_q, ballot_d;
  logic                    bv_q, bv_d;
  logic                    to_q, to_d;
  logic                    busy;

  logic                    open_w, start_w, close_w, full_w;
  logic [NUM_VOTERS-1:0]   new_w, vote_mrg, voted_mrg;

  assign open_w  = (state_q == S_OPEN);
  assign start_w = !open_w && bus.start;

  // Per-voter lock: only the first cast in a window is taken.
  for (genvar i = 0; i < NUM_VOTERS; i++) begin : g_voter
    assign new_w[i]     = open_w && bus.cast[i] && !voted_q[i];
    assign vote_mrg[i]  = new_w[i] ? bus.choice[i] : vote_q[i];
    assign voted_mrg[i] = voted_q[i] | new_w[i];
  end

  assign full_w  = (voted_mrg == {NUM_VOTERS{1'b1}});
  assign close_w = open_w && (full_w || (timer_q == '0));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_OPEN;
      S_OPEN:  if (close_w)   state_d = S_DONE;
      S_DONE:  if (bus.start) state_d = S_OPEN;
      default:                state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_q == S_OPEN);
  end

  // Datapath next-state
  always_comb begin
    timer_d  = timer_q;
    vote_d   = vote_q;
    voted_d  = voted_q;
    ballot_d = ballot_q;
    to_d     = to_q;
    bv_d     = close_w;
    if (start_w) begin
      timer_d = TIMER_INIT;
      vote_d  = '0;
      voted_d = '0;
      to_d    = 1'b0;
    end else if (open_w) begin
      vote_d  = vote_mrg;
      voted_d = voted_mrg;
      if (close_w) begin
        // Non-voters were cleared at start, so they land as "no".
        ballot_d = vote_mrg;
        to_d     = !full_w;
      end else if (timer_q != '0) begin
        timer_d = timer_q - TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      vote_q   <= '0;
      voted_q  <= '0;
      ballot_q <= '0;
      bv_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      vote_q   <= vote_d;
      voted_q  <= voted_d;
      ballot_q <= ballot_d;
      bv_q     <= bv_d;
      to_q     <= to_d;
    end
  end

  assign bus.ballot       = ballot_q;
  assign bus.ballot_valid = bv_q;
  assign bus.busy         = busy;
  assign bus.voted        = voted_q;
  assign bus.timed_out    = to_q;

endmodule

// File: doc/vote_collector.md
Name: vote_collector

Overview:
Upstream stage of the 4-voter decision path. It opens a timed voting window and captures at most one yes/no vote per voter. It closes the window when all four have voted or the timer expires, then presents a stable 4-bit ballot. The ballot drives the combinational majority classifier's 4-bit input directly, and a one-cycle ballot_valid marks each new result.

Parameters:
WINDOW_CYCLES, 1000, window length in clock cycles; legal range 1 .. 2^TIMER_W-1.
TIMER_W, 16, width of the window down-counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  opens a new window; sampled only in IDLE or DONE.
cast  input  4  per-voter vote strobe; bit i = voter i casting this cycle.
choice  input  4  per-voter value, sampled with cast[i]; 1 = yes, 0 = no.
ballot  output  4  closed ballot, bit i = voter i's vote; held stable between closes; feeds the classifier input.
ballot_valid  output  1  one-cycle pulse, first cycle ballot holds a new result.
busy  output  1  1 while window is open (state OPEN).
voted  output  4  live mask of voters already recorded in the current or last window.
timed_out  output  1  1 in DONE if window closed by timer with voted != 4'b1111.

Behaviour:
- Reset (async assert, sync release on clk): state=IDLE, ballot=0, ballot_valid=0, busy=0, voted=0, timed_out=0, timer=0, internal vote register=0. Reset mid-window discards all partial votes; no ballot_valid is produced.
- States: IDLE, OPEN, DONE. All outputs are registered.
- IDLE/DONE with start=1:
  - At the edge: state<=OPEN, voted<=0, internal votes<=0, timer<=WINDOW_CYCLES-1, timed_out<=0.
  - ballot keeps its previous value.
  - cast in the same cycle as start is ignored.
- OPEN, per cycle:
  - new = cast & ~voted. For each set bit i: voted[i]<=1, vote[i]<=choice[i].
  - First vote locks; repeated cast from a voted voter is ignored, even with a different choice.
  - Close condition: (voted|new)==4'b1111 OR timer==0.
  - On close: state<=DONE, ballot<=vote merged with this cycle's new votes, ballot_valid<=1 on the following cycle, timed_out<=((voted|new)!=4'b1111).
  - Otherwise: timer<=timer-1.
- Window timing: OPEN lasts exactly WINDOW_CYCLES cycles if not completed early. Votes in the last cycle (timer==0) are counted.
- Non-voters are recorded as 0 (no) in ballot.
- Latency: all four cast in the first OPEN cycle -> busy drops and ballot_valid=1 one cycle later.
- start while OPEN is ignored. cast in IDLE/DONE is ignored.
- ballot_valid is high for exactly 1 cycle per close, never in IDLE.
- DONE holds ballot, voted and timed_out until the next start.
- WINDOW_CYCLES=1: single-cycle window; close at end of that cycle.
- Timer never wraps: the decrement is suppressed at 0.

Test Plan:
- Reset, then start; cast=4'b1111, choice=4'b1011 in the first OPEN cycle -> next cycle ballot=4'b1011, ballot_valid=1 for 1 cycle, busy=0, timed_out=0.
- WINDOW_CYCLES=8; voters 0 and 2 vote yes, voters 1 and 3 silent -> close exactly 8 cycles after the start edge; ballot=4'b0101, timed_out=1, voted=4'b0101.
- Voter 1 casts yes, then casts no 2 cycles later, others complete with yes -> ballot=4'b1111 (first vote locked).
- Vote in the last window cycle (timer==0) with cast[3]=1, choice[3]=1 -> ballot[3]=1. Cast one cycle after close -> ignored, ballot unchanged.
- start pulse while OPEN plus a cast in IDLE -> no effect on timer, votes or state. Then start from DONE -> voted clears, previous ballot held until the new close.
- Assert rst_n=0 mid-window with 2 votes recorded -> all outputs 0 immediately, no ballot_valid. After release, start a full window -> normal ballot.
